vga_drawrect_axil_slave: RTL and testbench

AXI4-Lite responder for the vga_drawrect peripheral: accepts single-beat register writes and reads from the PS-side master, holds four 32-bit control registers, and drives the rectangle parameters (position, size, colour, enable) consumed by the VGA pixel pipeline. An optional frame-synchronous commit latches parameters only at frame start, so a rectangle never tears mid-frame.

---
 rtl/vga_drawrect_axil_slave.sv | 148 ++++++++++++++
 tb/tb_vga_drawrect_axil_slave.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_drawrect_axil_slave.sv
// AXI4-Lite register slave for the rectangle overlay: 4 R/W regs (POS, SIZE, COLOR, CTRL) driving active rect params.
// Latency: write ready 1 cycle after AW+W valid, BVALID on the handshake edge; reads likewise (ARREADY, then RVALID).
// Backpressure: BVALID/RVALID hold until BREADY/RREADY; no new write while BVALID=1, no new read while RVALID=1.
//
// Ports: S_AXI_* is the AXI4-Lite slave (ACLK, async active-low ARESETN).
//        frame_start is a 1-cycle pulse at the first pixel of each frame.
//        rect_* are the active parameters. commit_pending flags regs != active while in sync mode.
module vga_drawrect_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            frame_start,
  output logic [10:0]                     rect_x,
  output logic [10:0]                     rect_y,
  output logic [10:0]                     rect_w,
  output logic [10:0]                     rect_h,
  output logic [23:0]                     rect_color,
  output logic                            rect_en,
  output logic                            commit_pending
);

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] w;
    logic [10:0] h;
    logic [23:0] color;
    logic        en;
  } rect_t;

  localparam int NBYTES = C_S_AXI_DATA_WIDTH / 8;

  logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [4];
  logic                          r_awready;
  logic                          r_bvalid;
  logic                          r_arready;
  logic                          r_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  rect_t                         r_act;

  logic       w_wr_hs;
  logic       w_rd_hs;
  logic [1:0] w_waddr;
  logic [1:0] w_raddr;
  logic       w_sync;
  rect_t      w_reg_rect;
  logic       w_unused;

  assign w_waddr  = S_AXI_AWADDR[3:2];
  assign w_raddr  = S_AXI_ARADDR[3:2];
  // Ready is only ever raised while the matching valids are high, so the
  // handshake edge is simply "ready was high and valids are still high".
  assign w_wr_hs  = r_awready && S_AXI_AWVALID && S_AXI_WVALID;
  assign w_rd_hs  = r_arready && S_AXI_ARVALID;
  assign w_sync   = r_regs[3][1];
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign w_reg_rect = {r_regs[0][10:0], r_regs[0][26:16], r_regs[1][10:0],
                       r_regs[1][26:16], r_regs[2][23:0], r_regs[3][0]};

  // Write channel: AW and W are accepted together, never one alone.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_awready <= !r_awready && S_AXI_AWVALID && S_AXI_WVALID && !r_bvalid;
      if (w_wr_hs)
        r_bvalid <= 1'b1;
      else if (r_bvalid && S_AXI_BREADY)
        r_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else if (w_wr_hs) begin
      for (int b = 0; b < NBYTES; b++)
        if (S_AXI_WSTRB[b]) r_regs[w_waddr][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
    end
  end

  // Read channel: RDATA samples the pre-write register value on a
  // same-edge read/write collision, since both are flop outputs.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= !r_arready && S_AXI_ARVALID && !r_rvalid;
      if (w_rd_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= r_regs[w_raddr];
      end else if (r_rvalid && S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Active params: free-running copy, or frame-start-only copy in sync mode.
  // A write landing on the frame_start edge is not seen until the next frame.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)
      r_act <= '0;
    else if (!w_sync || frame_start)
      r_act <= w_reg_rect;
  end

  assign S_AXI_AWREADY  = r_awready;
  assign S_AXI_WREADY   = r_awready;
  assign S_AXI_BRESP    = 2'b00;
  assign S_AXI_BVALID   = r_bvalid;
  assign S_AXI_ARREADY  = r_arready;
  assign S_AXI_RDATA    = r_rdata;
  assign S_AXI_RRESP    = 2'b00;
  assign S_AXI_RVALID   = r_rvalid;
  assign rect_x         = r_act.x;
  assign rect_y         = r_act.y;
  assign rect_w         = r_act.w;
  assign rect_h         = r_act.h;
  assign rect_color     = r_act.color;
  assign rect_en        = r_act.en;
  assign commit_pending = w_sync && (w_reg_rect != r_act);

endmodule

// File: tb/tb_vga_drawrect_axil_slave.sv
// Bench for vga_drawrect_axil_slave: directed scenarios plus randomized AXI traffic,
// with a per-cycle reference model compared on every falling clock edge.
module tb_vga_drawrect_axil_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic        frame_start;
  logic [10:0] rect_x, rect_y, rect_w, rect_h;
  logic [23:0] rect_color;
  logic        rect_en, commit_pending;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vga_drawrect_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .frame_start(frame_start),
    .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
    .rect_color(rect_color), .rect_en(rect_en), .commit_pending(commit_pending)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Registers, active parameters and handshake state as the block's rules
  // dictate, advanced once per clock from the inputs visible before the edge.
  logic [31:0] m_reg [4];
  logic [10:0] m_x, m_y, m_w, m_h;
  logic [23:0] m_col;
  logic        m_en;
  logic        m_awr, m_bv, m_arr, m_rv;
  logic [31:0] m_rd;
  logic        mon_w_hs = 1'b0, mon_r_hs = 1'b0;

  always @(negedge clk) begin
    logic hs_w, hs_r, n_awr, n_arr, exp_pend;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_reg[i] = '0;
      {m_x, m_y, m_w, m_h, m_col, m_en} = '0;
      {m_awr, m_bv, m_arr, m_rv} = '0;
      m_rd = '0;
    end
    exp_pend = m_reg[3][1] &&
               ({m_reg[0][10:0], m_reg[0][26:16], m_reg[1][10:0], m_reg[1][26:16], m_reg[2][23:0], m_reg[3][0]}
                != {m_x, m_y, m_w, m_h, m_col, m_en});
    chk("awready", 32'(awready), 32'(m_awr));
    chk("wready", 32'(wready), 32'(m_awr));
    chk("bvalid", 32'(bvalid), 32'(m_bv));
    chk("bresp", 32'(bresp), 32'h0);
    chk("arready", 32'(arready), 32'(m_arr));
    chk("rvalid", 32'(rvalid), 32'(m_rv));
    chk("rdata", rdata, m_rd);
    chk("rresp", 32'(rresp), 32'h0);
    chk("rect_x", 32'(rect_x), 32'(m_x));
    chk("rect_y", 32'(rect_y), 32'(m_y));
    chk("rect_w", 32'(rect_w), 32'(m_w));
    chk("rect_h", 32'(rect_h), 32'(m_h));
    chk("rect_color", 32'(rect_color), 32'(m_col));
    chk("rect_en", 32'(rect_en), 32'(m_en));
    chk("commit_pending", 32'(commit_pending), 32'(exp_pend));
    if (rst_n) begin
      hs_w  = m_awr && awvalid && wvalid;
      hs_r  = m_arr && arvalid;
      n_awr = !m_awr && awvalid && wvalid && !m_bv;
      n_arr = !m_arr && arvalid && !m_rv;
      if (!m_reg[3][1] || frame_start) begin
        m_x = m_reg[0][10:0];  m_y = m_reg[0][26:16];
        m_w = m_reg[1][10:0];  m_h = m_reg[1][26:16];
        m_col = m_reg[2][23:0]; m_en = m_reg[3][0];
      end
      if (hs_r) m_rd = m_reg[araddr[3:2]];
      m_rv  = hs_r ? 1'b1 : (rready ? 1'b0 : m_rv);
      m_bv  = hs_w ? 1'b1 : (bready ? 1'b0 : m_bv);
      m_awr = n_awr;
      m_arr = n_arr;
      if (hs_w)
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) m_reg[awaddr[3:2]][8*b +: 8] = wdata[8*b +: 8];
      mon_w_hs = hs_w;
      mon_r_hs = hs_r;
    end else begin
      mon_w_hs = 1'b0;
      mon_r_hs = 1'b0;
    end
  end

  // ---------------- directed helpers (entered just after a rising edge) ----------------
  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 20);
    chk("aw_latency", 32'(n), 32'd2);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < 20);
    chk("b_latency", 32'(n), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    araddr = a; arvalid = 1; rready = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 20);
    chk("ar_latency", 32'(n), 32'd2);
    @(posedge clk); #1;
    arvalid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 20);
    chk("r_latency", 32'(n), 32'd1);
    d = rdata;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] d, d0;
    int n;
    logic acc, lost;
    rst_n = 0; awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
    awvalid = 0; wvalid = 0; wdata = 0; wstrb = 0; bready = 0;
    arvalid = 0; rready = 0; frame_start = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_bvalid", 32'(bvalid), 32'h0);
    chk("reset_rect_x", 32'(rect_x), 32'h0);
    rst_n = 1;

    // Sequential write/readback
    for (int i = 0; i < 4; i++) do_write(4'(i*4), 32'(i+1), 4'hF);
    for (int i = 0; i < 4; i++) begin
      do_read(4'(i*4), d);
      chk("seq_readback", d, 32'(i+1));
    end
    chk("seq_rect_x", 32'(rect_x), 32'd1);
    chk("seq_rect_w", 32'(rect_w), 32'd2);
    chk("seq_rect_color", 32'(rect_color), 32'd3);
    chk("seq_rect_en", 32'(rect_en), 32'd0);

    // Byte strobes
    do_write(4'h8, 32'hFFFF_FFFF, 4'hF);
    do_write(4'h8, 32'h1234_5678, 4'b0101);
    do_read(4'h8, d);
    chk("wstrb_readback", d, 32'hFF34_FF78);

    // Frame-synchronous commit
    do_write(4'hC, 32'h3, 4'hF);
    do_write(4'h0, 32'h0064_0032, 4'hF);
    chk("sync_hold_x", 32'(rect_x), 32'd1);
    chk("sync_hold_y", 32'(rect_y), 32'd0);
    chk("sync_pending", 32'(commit_pending), 32'd1);
    frame_start = 1;
    @(posedge clk); #1;
    frame_start = 0;
    chk("sync_commit_x", 32'(rect_x), 32'd50);
    chk("sync_commit_y", 32'(rect_y), 32'd100);
    chk("sync_commit_pending", 32'(commit_pending), 32'd0);

    // Write response backpressure with a second write waiting
    awaddr = 4'h8; wdata = 32'hA5A5_A5A5; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 20);
    chk("bp_aw_latency", 32'(n), 32'd2);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    chk("bp_bvalid_up", 32'(bvalid), 32'd1);
    @(posedge clk); #1;
    awaddr = 4'h4; wdata = 32'h0003_0004; awvalid = 1; wvalid = 1;
    acc = 0; lost = 0;
    repeat (10) begin
      @(negedge clk);
      if (awready || wready) acc = 1;
      if (!bvalid) lost = 1;
    end
    chk("bp_no_second_accept", 32'(acc), 32'd0);
    chk("bp_bvalid_held", 32'(lost), 32'd0);
    @(posedge clk); #1;
    bready = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 20);
    chk("bp_second_latency", 32'(n), 32'd3);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    @(posedge clk); #1;

    // Read data backpressure
    araddr = 4'h8; arvalid = 1; rready = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 20);
    @(posedge clk); #1;
    arvalid = 0;
    @(negedge clk);
    d0 = rdata;
    chk("bp_rdata", d0, 32'hA5A5_A5A5);
    lost = 0;
    repeat (10) begin
      @(negedge clk);
      if (!rvalid || rdata !== d0) lost = 1;
    end
    chk("bp_rdata_stable", 32'(lost), 32'd0);
    @(posedge clk); #1;
    rready = 1;
    @(posedge clk); #1;
    do_read(4'h4, d);
    chk("bp_second_write", d, 32'h0003_0004);

    // Skewed AW then W
    awaddr = 4'h0; wdata = 32'h0; awvalid = 1; wvalid = 0;
    acc = 0;
    repeat (5) begin
      @(negedge clk);
      if (awready || wready) acc = 1;
    end
    chk("skew_no_ready", 32'(acc), 32'd0);
    @(posedge clk); #1;
    wdata = 32'h0123_0456; wstrb = 4'hF; wvalid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 20);
    chk("skew_latency", 32'(n), 32'd2);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    @(posedge clk); #1;
    do_read(4'h0, d);
    chk("skew_readback", d, 32'h0123_0456);

    // Reset while a write response is outstanding
    awaddr = 4'h8; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 20);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    chk("rst_pre_bvalid", 32'(bvalid), 32'd1);
    #2;
    rst_n = 0;
    #1;
    chk("rst_bvalid_drop", 32'(bvalid), 32'd0);
    chk("rst_color", 32'(rect_color), 32'd0);
    bready = 1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      do_read(4'(i*4), d);
      chk("rst_readback", d, 32'h0);
    end

    // Randomized traffic, valids held until their handshake
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (mon_w_hs) begin awvalid = 0; wvalid = 0; end
      if (mon_r_hs) arvalid = 0;
      if (!awvalid && $urandom_range(0, 3) == 0) begin
        awvalid = 1; awaddr = 4'($urandom_range(0, 15));
      end
      if (!wvalid && $urandom_range(0, 3) == 0) begin
        wvalid = 1; wdata = $urandom; wstrb = 4'($urandom_range(0, 15));
      end
      if (!arvalid && $urandom_range(0, 2) == 0) begin
        arvalid = 1; araddr = 4'($urandom_range(0, 15));
      end
      bready = ($urandom_range(0, 3) != 0);
      rready = ($urandom_range(0, 3) != 0);
      frame_start = ($urandom_range(0, 7) == 0);
    end
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
